// File: rtl/button_step_pulser.sv
// Push-button front end: 2-FF synchronizer, debounce FSM, optional hold-to-repeat,
// and a wrapping count of the single-cycle step pulses issued.
module button_step_pulser #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned HOLD_CYCLES     = 64,
    parameter int unsigned REPEAT_CYCLES   = 16,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_in,
    output logic               step,
    output logic               pressed,
    output logic [COUNT_W-1:0] press_count
);

    localparam int unsigned MaxAB  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                     : HOLD_CYCLES;
    localparam int unsigned MaxAll = (MaxAB > REPEAT_CYCLES) ? MaxAB : REPEAT_CYCLES;
    localparam int unsigned CNT_W  = (MaxAll > 1) ? $clog2(MaxAll) : 1;

    localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StHeld,
        StDebRelease
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_timer;
    logic               r_rep_phase;
    logic               r_step;
    logic               r_pressed;
    logic [COUNT_W-1:0] r_press_count;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic               w_rep_phase_nxt;
    logic               w_step_nxt;
    logic               w_pressed_nxt;
    logic [CNT_W-1:0]   w_timer_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_timer       <= '0;
            r_rep_phase   <= 1'b0;
            r_step        <= 1'b0;
            r_pressed     <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_sync1       <= btn_in;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timer       <= w_timer_nxt;
            r_rep_phase   <= w_rep_phase_nxt;
            r_step        <= w_step_nxt;
            r_pressed     <= w_pressed_nxt;
            if (w_step_nxt) begin
                r_press_count <= r_press_count + COUNT_W'(1);
            end
        end
    end

    // First repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES.
    assign w_timer_last = r_rep_phase ? RepLast : HoldLast;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_timer_nxt     = r_timer;
        w_rep_phase_nxt = r_rep_phase;
        w_step_nxt      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_sync2) begin
                    w_state_nxt = StDebPress;
                    w_cnt_nxt   = '0;
                end
            end
            StDebPress: begin
                if (!r_sync2) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DebLast) begin
                    w_state_nxt     = StHeld;
                    w_step_nxt      = 1'b1;
                    w_timer_nxt     = '0;
                    w_rep_phase_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            StHeld: begin
                if (!r_sync2) begin
                    w_state_nxt = StDebRelease;
                    w_cnt_nxt   = '0;
                end else if (REPEAT_EN != 0) begin
                    // At the compare point the timer parks until the previous pulse has dropped.
                    if (r_timer == w_timer_last) begin
                        if (!r_step) begin
                            w_step_nxt      = 1'b1;
                            w_timer_nxt     = '0;
                            w_rep_phase_nxt = 1'b1;
                        end
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
            end
            StDebRelease: begin
                if (r_sync2) begin
                    w_state_nxt = StHeld;
                end else if (r_cnt == DebLast) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        w_pressed_nxt = (w_state_nxt == StHeld) || (w_state_nxt == StDebRelease);
    end

    assign step        = r_step;
    assign pressed     = r_pressed;
    assign press_count = r_press_count;

endmodule

// File: doc/button_step_pulser.md
Name: button_step_pulser

Overview:
- Upstream stage for the modulo counter. Turns a raw, bouncing push-button into clean single-cycle step pulses that drive the counter's advance input.
- Contains a 2-FF synchronizer, a debounce FSM, optional hold-to-auto-repeat and a wrapping count of issued steps.
- Everything is in one clock domain. Only btn_in is asynchronous.

Parameters:
- DEBOUNCE_CYCLES, 16: number of consecutive stable synchronized samples needed to accept a press or a release. Must be >= 1.
- REPEAT_EN, 0: 1 enables auto-repeat while the button is held; 0 disables it.
- HOLD_CYCLES, 64: cycles in HELD after the initial step before the first repeat step. Must be >= 1.
- REPEAT_CYCLES, 16: period between repeat steps after the first repeat. Must be >= 1.
- COUNT_W, 8: width of press_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_in  in  1  raw button level, asynchronous, active-high.
- step  out  1  one-cycle pulse per accepted press or repeat; feeds the counter advance.
- pressed  out  1  debounced button level.
- press_count  out  COUNT_W  total steps issued; wraps.

Behaviour:
- Reset (reset=0, async):
  - sync FFs = 0, FSM = IDLE, all timers = 0.
  - step = 0, pressed = 0, press_count = 0, effective immediately without waiting for a clock edge.
- Synchronizer: btn_in -> ff1 -> ff2 (btn_s). The FSM uses only btn_s.
- FSM states:
  - IDLE: if btn_s=1, go to DEB_PRESS and set cnt=0.
  - DEB_PRESS:
    - btn_s=0: go to IDLE, clear cnt. This is a bounce; no step.
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, register step=1, clear hold timer.
    - otherwise: cnt++.
  - HELD:
    - btn_s=0: go to DEB_RELEASE, set cnt=0, freeze the hold/repeat timer.
    - otherwise, if REPEAT_EN=1: advance the timer. Issue a step when it reaches HOLD_CYCLES-1, then every REPEAT_CYCLES thereafter.
  - DEB_RELEASE:
    - btn_s=1: return to HELD with no step; the repeat timer resumes from its frozen value.
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - otherwise: cnt++.
- Outputs:
  - pressed = 1 exactly while the FSM is in HELD or DEB_RELEASE. It is registered and rises in the same cycle as the initial step.
  - step is registered and high for exactly one cycle per event. It is never high in two consecutive cycles, even if REPEAT_CYCLES=1.
  - For REPEAT_CYCLES=1, repeat steps occur every 2 cycles (one high, one low).
- Latency: count edge 1 as the first clk edge sampling btn_in=1. With btn_in held high, step is high in the cycle after edge 3+DEBOUNCE_CYCLES.
- Release latency: pressed falls after edge 3+DEBOUNCE_CYCLES, counted from the first edge sampling btn_in=0.
- press_count: increments by 1 on every cycle where step=1 and wraps from 2^COUNT_W-1 to 0 with no flag. The count updates on the same edge that raises step.
- Counter widths are sized with $clog2 of the largest parameter. No counter may overflow before its compare point.
- Boundary conditions:
  - A bounce lasting 1 cycle in btn_s during DEB_PRESS restarts the debounce; a step requires DEBOUNCE_CYCLES fresh stable samples.
  - A release glitch shorter than DEBOUNCE_CYCLES never ends HELD and never produces an extra step.
  - With DEBOUNCE_CYCLES=1, step comes 4 edges after the input edge.
  - Reset asserted mid-debounce or mid-HELD aborts at once. If the button is still held after reset deasserts, the full debounce reruns and produces a new step.
  - Reset deassertion is synchronized by the system; the block needs no extra handling.

Test Plan:
- DEBOUNCE_CYCLES=4, REPEAT_EN=0; clean press held 20 cycles, then released -> step high in the cycle after edge 7 only; pressed high from that cycle; pressed low 7 edges after release; press_count=1.
- Press toggling every 2 cycles for 12 cycles, then held stable -> no step during toggling; exactly one step 7 edges after the final rising sample; press_count=1.
- While HELD, a 2-cycle low glitch with DEBOUNCE_CYCLES=4 -> pressed stays 1; no additional step; press_count unchanged.
- REPEAT_EN=1, HOLD_CYCLES=8, REPEAT_CYCLES=4; hold for 30 cycles past the initial step -> steps at +0, +8, +12, +16, +20, +24, +28 cycles relative to the initial step; press_count=7.
- COUNT_W=3; 9 separate debounced presses -> press_count sequence 1..7, 0, 1; step pulses each exactly 1 cycle.
- Reset pulled low 2 cycles into HELD with the button kept high -> step=0, pressed=0, press_count=0 immediately. After reset release, a new step arrives 3+DEBOUNCE_CYCLES edges later and press_count=1.
